// File: rtl/pipeline_flow_controller_pkg.sv
// Shared FSM encoding and occupancy-width helper for the pipeline flow controller.
`ifndef PIPELINE_FLOW_CONTROLLER_PKG_SV
`define PIPELINE_FLOW_CONTROLLER_PKG_SV
package pipeline_flow_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_e;

  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage
`endif

// File: rtl/pipeline_flow_controller_stage_ctrl.sv
// Valid flag and load enable for one pipeline register stage.
module pipeline_stage_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic ready,
  input  logic up_valid,
  input  logic accept,
  output logic enable,
  output logic valid
);

  assign enable = ready & up_valid & accept;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
    end else if (enable) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_flow_controller.sv
// Valid/ready flow control for a STAGES-deep pipeline whose data registers live outside.
module pipeline_flow_controller
  import pipeline_flow_controller_pkg::*;
#(
  parameter  int unsigned STAGES = 2,
  localparam int unsigned OW     = occ_width(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [STAGES-1:0] stage_enable,
  output logic [STAGES-1:0] stage_valid,
  input  logic              flush,
  input  logic              drain_req,
  output logic              drain_done,
  output logic [OW-1:0]     occupancy
);

  ctrl_state_e       state;
  ctrl_state_e       state_next;
  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] accept;
  logic              in_fire;
  logic              out_fire;
  logic              done_next;
  logic              drain_req_q;
  logic [OW-1:0]     occ_next;

  // A stage can move when it is empty or everything downstream of it can move.
  always_comb begin
    ready = '0;
    ready[STAGES-1] = ~stage_valid[STAGES-1] | out_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      ready[i] = ~stage_valid[i] | ready[i+1];
    end
  end

  // Stage 0 loads from upstream gated by in_ready; later stages load from their predecessor.
  always_comb begin
    up_valid    = stage_valid << 1;
    up_valid[0] = in_valid;
    accept      = {STAGES{~flush}};
    accept[0]   = in_ready;
  end

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
    pipeline_stage_ctrl u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .ready    (ready[g]),
      .up_valid (up_valid[g]),
      .accept   (accept[g]),
      .enable   (stage_enable[g]),
      .valid    (stage_valid[g])
    );
  end

  assign out_valid = stage_valid[STAGES-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    if (flush) begin
      occ_next = '0;
    end else begin
      occ_next = occupancy + OW'(in_fire) - OW'(out_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      drain_done  <= 1'b0;
      drain_req_q <= 1'b0;
    end else begin
      state       <= state_next;
      drain_done  <= done_next;
      drain_req_q <= drain_req;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (occ_next == '0)  state_next = IDLE;
          else if (drain_req)  state_next = DRAIN;
          else                 state_next = RUN;
        end
        DRAIN: begin
          if (occ_next == '0)  state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Completion pulse: end of a real drain, or a fresh drain request that finds nothing to empty.
  always_comb begin
    in_ready  = ready[0] & ~flush & (state != DRAIN) & ~drain_req;
    done_next = 1'b0;
    if (flush) begin
      done_next = (state == DRAIN);
    end else if (state == DRAIN) begin
      done_next = (occ_next == '0);
    end else begin
      done_next = drain_req & ~drain_req_q & (occ_next == '0);
    end
  end

endmodule

// File: tb/tb_pipeline_flow_controller.sv
// Directed scenario bench for pipeline_flow_controller with STAGES=4.
module tb_pipeline_flow_controller;

  localparam int unsigned STAGES = 4;
  localparam int unsigned OW     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [STAGES-1:0] stage_enable;
  logic [STAGES-1:0] stage_valid;
  logic              flush;
  logic              drain_req;
  logic              drain_done;
  logic [OW-1:0]     occupancy;

  int total = 0;
  int bad   = 0;

  pipeline_flow_controller #(.STAGES(STAGES)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .stage_enable (stage_enable),
    .stage_valid  (stage_valid),
    .flush        (flush),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    drain_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    total++; if (stage_valid !== 4'b0000) begin bad++; $display("FAIL reset_stage_valid got=%b want=%b", stage_valid, 4'b0000); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=%0d", occupancy, 0); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain_done got=%b want=%b", drain_done, 1'b0); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=%b", out_valid, 1'b0); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=%b", in_ready, 1'b1); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [3:0] exp_sv;
    logic [3:0] exp_en;
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    exp_sv    = 4'b0000;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      #1;
      exp_en = 4'((exp_sv << 1) | 4'b0001);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready c%0d got=%b want=%b", cyc, in_ready, 1'b1); end
      total++; if (stage_enable !== exp_en) begin bad++; $display("FAIL stream_enable c%0d got=%b want=%b", cyc, stage_enable, exp_en); end
      step();
      exp_sv = 4'((exp_sv << 1) | 4'b0001);
      total++; if (stage_valid !== exp_sv) begin bad++; $display("FAIL stream_stage_valid c%0d got=%b want=%b", cyc, stage_valid, exp_sv); end
      total++; if (out_valid !== (cyc >= 4)) begin bad++; $display("FAIL stream_out_valid c%0d got=%b want=%b", cyc, out_valid, (cyc >= 4)); end
      total++; if (occupancy !== 3'((cyc < 4) ? cyc : 4)) begin bad++; $display("FAIL stream_occupancy c%0d got=%0d want=%0d", cyc, occupancy, (cyc < 4) ? cyc : 4); end
    end
    in_valid = 1'b0;
    repeat (4) step();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL stream_empty_occ got=%0d want=%0d", occupancy, 0); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_empty_out_valid got=%b want=%b", out_valid, 1'b0); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1;
    repeat (4) step();
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL bp_full_occ got=%0d want=%0d", occupancy, 4); end
    total++; if (stage_valid !== 4'b1111) begin bad++; $display("FAIL bp_full_sv got=%b want=%b", stage_valid, 4'b1111); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b want=%b", in_ready, 1'b0); end
    total++; if (stage_enable !== 4'b0000) begin bad++; $display("FAIL bp_full_enable got=%b want=%b", stage_enable, 4'b0000); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=%b", in_ready, 1'b1); end
    total++; if (stage_enable !== 4'b1110) begin bad++; $display("FAIL bp_release_enable got=%b want=%b", stage_enable, 4'b1110); end
    step();
    out_ready = 1'b0;
    #1;
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL bp_one_out_occ got=%0d want=%0d", occupancy, 3); end
    total++; if (stage_valid !== 4'b1110) begin bad++; $display("FAIL bp_one_out_sv got=%b want=%b", stage_valid, 4'b1110); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_hole_in_ready got=%b want=%b", in_ready, 1'b1); end
  endtask

  task automatic test_bubble();
    do_reset();
    in_valid = 1'b1;
    step();
    total++; if (stage_valid !== 4'b0001) begin bad++; $display("FAIL bubble_e1 got=%b want=%b", stage_valid, 4'b0001); end
    in_valid = 1'b0;
    step();
    step();
    total++; if (stage_valid !== 4'b0100) begin bad++; $display("FAIL bubble_e3 got=%b want=%b", stage_valid, 4'b0100); end
    in_valid = 1'b1;
    step();
    total++; if (stage_valid !== 4'b1001) begin bad++; $display("FAIL bubble_e4 got=%b want=%b", stage_valid, 4'b1001); end
    in_valid = 1'b0;
    repeat (3) step();
    total++; if (stage_valid !== 4'b1100) begin bad++; $display("FAIL bubble_collapsed got=%b want=%b", stage_valid, 4'b1100); end
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL bubble_occ got=%0d want=%0d", occupancy, 2); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bubble_out_valid got=%b want=%b", out_valid, 1'b1); end
  endtask

  task automatic test_drain();
    do_reset();
    in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    step();
    total++; if (stage_valid !== 4'b1110) begin bad++; $display("FAIL drain_setup_sv got=%b want=%b", stage_valid, 4'b1110); end
    drain_req = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL drain_in_ready got=%b want=%b", in_ready, 1'b0); end
    total++; if (stage_enable !== 4'b1100) begin bad++; $display("FAIL drain_enable got=%b want=%b", stage_enable, 4'b1100); end
    step();
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL drain_d1_done got=%b want=%b", drain_done, 1'b0); end
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL drain_d1_occ got=%0d want=%0d", occupancy, 2); end
    step();
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL drain_d2_done got=%b want=%b", drain_done, 1'b0); end
    step();
    total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL drain_d3_done got=%b want=%b", drain_done, 1'b1); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL drain_d3_occ got=%0d want=%0d", occupancy, 0); end
    step();
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL drain_d4_done got=%b want=%b", drain_done, 1'b0); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL drain_d4_no_accept got=%0d want=%0d", occupancy, 0); end
    step();
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL drain_held_done got=%b want=%b", drain_done, 1'b0); end
    in_valid  = 1'b0;
    drain_req = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_idle_in_ready got=%b want=%b", in_ready, 1'b1); end
    step();
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL drain_low_done got=%b want=%b", drain_done, 1'b0); end
    drain_req = 1'b1;
    step();
    total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL drain_empty_done got=%b want=%b", drain_done, 1'b1); end
    step();
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL drain_empty_once got=%b want=%b", drain_done, 1'b0); end
    drain_req = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    repeat (4) step();
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL flush_setup_occ got=%0d want=%0d", occupancy, 4); end
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=%b", in_ready, 1'b0); end
    total++; if (stage_enable !== 4'b0000) begin bad++; $display("FAIL flush_enable got=%b want=%b", stage_enable, 4'b0000); end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (stage_valid !== 4'b0000) begin bad++; $display("FAIL flush_sv got=%b want=%b", stage_valid, 4'b0000); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d want=%0d", occupancy, 0); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL flush_no_done got=%b want=%b", drain_done, 1'b0); end
    step();
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL flush_no_done_late got=%b want=%b", drain_done, 1'b0); end
    // flush while draining finishes the drain
    in_valid = 1'b1;
    repeat (2) step();
    in_valid  = 1'b0;
    drain_req = 1'b1;
    step();
    drain_req = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flushdrain_in_drain got=%b want=%b", in_ready, 1'b0); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL flushdrain_done got=%b want=%b", drain_done, 1'b1); end
    total++; if (stage_valid !== 4'b0000) begin bad++; $display("FAIL flushdrain_sv got=%b want=%b", stage_valid, 4'b0000); end
    step();
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL flushdrain_once got=%b want=%b", drain_done, 1'b0); end
  endtask

  task automatic test_rst_drain();
    do_reset();
    in_valid = 1'b1;
    repeat (3) step();
    in_valid  = 1'b0;
    drain_req = 1'b1;
    step();
    drain_req = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstdrain_in_drain got=%b want=%b", in_ready, 1'b0); end
    drain_req = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b1;
    step();
    total++; if (stage_valid !== 4'b0000) begin bad++; $display("FAIL rstdrain_sv got=%b want=%b", stage_valid, 4'b0000); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rstdrain_occ got=%0d want=%0d", occupancy, 0); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL rstdrain_done got=%b want=%b", drain_done, 1'b0); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstdrain_out_valid got=%b want=%b", out_valid, 1'b0); end
    rst       = 1'b0;
    drain_req = 1'b0;
    out_ready = 1'b0;
    step();
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL rstdrain_no_pulse got=%b want=%b", drain_done, 1'b0); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstdrain_in_ready got=%b want=%b", in_ready, 1'b1); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_drain();
    test_flush();
    test_rst_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_flow_controller.md
PIPELINE_FLOW_CONTROLLER -- requirements
Module: pipeline_flow_controller

Interface
REQ-001 SHALL have parameter STAGES, default 2: number of pipeline register stages controlled, legal range 1..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-005 SHALL have port in_ready, output, 1 bit: controller accepts upstream data this cycle.
REQ-006 SHALL have port out_valid, output, 1 bit: last stage holds valid data.
REQ-007 SHALL have port out_ready, input, 1 bit: downstream accepts data this cycle.
REQ-008 SHALL have port stage_enable, output, STAGES bits: load enable for the external data register of each stage; bit 0 is the input stage.
REQ-009 SHALL have port stage_valid, output, STAGES bits: registered valid flag per stage.
REQ-010 SHALL have port flush, input, 1 bit: discard all in-flight data.
REQ-011 SHALL have port drain_req, input, 1 bit: stop accepting and empty the pipeline.
REQ-012 SHALL have port drain_done, output, 1 bit: one-cycle pulse when a drain completes.
REQ-013 SHALL have port occupancy, output, $clog2(STAGES+1) bits: count of valid stages.

Function
REQ-014 Stage readiness SHALL be combinational: ready[STAGES-1] = ~stage_valid[STAGES-1] | out_ready; ready[i] = ~stage_valid[i] | ready[i+1] (bubble collapsing).
REQ-015 in_ready SHALL equal ready[0] & ~flush & (state != DRAIN) & ~drain_req.
REQ-016 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; out_valid SHALL equal stage_valid[STAGES-1].
REQ-017 stage_enable[0] SHALL equal in_fire; stage_enable[i>0] SHALL equal ready[i] & stage_valid[i-1] & ~flush.
REQ-018 Next stage_valid[i] SHALL be: stage_enable-driven load sets it; otherwise cleared when ready[i] is asserted; otherwise held.
REQ-019 With no stalls, data accepted in cycle t SHALL present out_valid in cycle t+STAGES.
REQ-020 occupancy SHALL update by +in_fire -out_fire each cycle, never exceeding STAGES or going below 0; it SHALL always equal popcount(stage_valid).
REQ-021 FSM states SHALL be IDLE (empty), RUN (occupancy>0), DRAIN.
REQ-022 IDLE->RUN on in_fire; RUN->IDLE when next occupancy is 0; IDLE or RUN->DRAIN on drain_req when next occupancy is nonzero.
REQ-023 drain_req in IDLE, or in RUN with next occupancy 0, SHALL stay/go IDLE and pulse drain_done in the following cycle.
REQ-024 DRAIN->IDLE when next occupancy is 0; drain_done SHALL be high for exactly the first cycle in IDLE.
REQ-025 flush SHALL clear all stage_valid and occupancy next cycle, force IDLE, and take priority over in_valid, out_ready and drain_req; out_fire in the flush cycle SHALL still count as a transfer.
REQ-026 flush during DRAIN SHALL complete the drain and pulse drain_done next cycle; flush outside DRAIN SHALL not pulse drain_done.
REQ-027 drain_req held high SHALL not retrigger drain_done while IDLE and empty more than once per rising edge of drain_req.

Reset
REQ-028 While rst is high at a clock edge: stage_valid=0, occupancy=0, drain_done=0, state=IDLE; in_ready then follows REQ-015 (1 when no drain_req/flush).
REQ-029 rst mid-operation SHALL discard in-flight data without a drain_done pulse; rst SHALL override flush and drain_req.

Structure
REQ-030 FSM state encodings and the occupancy-width function SHALL live in a shared include header with an include guard.
REQ-031 Per-stage valid/ready logic SHALL be a sub-module pipeline_stage_ctrl, instantiated STAGES times via generate.
REQ-032 The controller SHALL contain no data path; data registers stay external, enabled by stage_enable.

Verification
REQ-033 STAGES=4, in_valid=1, out_ready=1 for 8 cycles -> first out_valid in cycle 4, out_valid continuous thereafter, occupancy steady at 4.
REQ-034 STAGES=4, fill 4 items with out_ready=0 -> in_ready=0 at occupancy 4; raise out_ready 1 cycle -> one out_fire, in_ready=1 same cycle.
REQ-035 Bubble: item, 2 idle cycles, item, out_ready=0 -> items collapse into stages 3 and 2, occupancy=2.
REQ-036 drain_req with occupancy 3, out_ready=1 -> in_ready=0 immediately, drain_done pulses exactly once 3 cycles later, state IDLE.
REQ-037 flush with occupancy 4 and in_valid=1 -> next cycle stage_valid=0, occupancy=0, no input accepted, no drain_done.
REQ-038 rst asserted during DRAIN -> next cycle all outputs at reset values, no drain_done pulse.
